ucsbece154b_dmem_resp: RTL
==========================

# ucsbece154b_dmem_resp

Multi-cycle data-memory responder that answers the processor's load/store requests over a req/ready handshake with a configurable access latency. It replaces the single-cycle data memory behind `ucsbece154b_top` so that the pipeline's memory-stall logic can be exercised. Storage is a word array named `DATA`, which benches inspect hierarchically. The base address matches the existing data segment at 0x10000000.

## Interface
- `WORDS`, 64, number of 32-bit words; power of two.
- `BASE`, 32'h10000000, byte address of `DATA[0]`.
- `LATENCY`, 2, cycles from request acceptance to response; legal range 1..15.

- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  request valid; held with its fields until `ready_o`.
- `we_i`  in  1  1 = store word, 0 = load word.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data.
- `rdata_o`  out  32  load data; valid while `ready_o` is high, then held.
- `ready_o`  out  1  one-cycle response strobe.
- `err_o`  out  1  response is an error; valid with `ready_o`, then held.
- `busy_o`  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP. All outputs are registered or decoded from state: `ready_o` = (state==RESP), `busy_o` = (state!=IDLE).
- IDLE: on a rising edge with `req_i`=1, capture `we_i`, `addr_i`, `wdata_i` into internal registers, load `cnt` with LATENCY-1 (4-bit), and go to WAIT. With `req_i`=0, stay in IDLE.
- WAIT: when `cnt`!=0, decrement. When `cnt`==0, perform the access on that edge and go to RESP. Changes on `req_i` or the request fields during WAIT are ignored; only the captured values are used.
- Access (uses captured values only):
  - Index = (addr − BASE) >> 2, truncated to log2(WORDS) bits.
  - Error if addr < BASE, addr ≥ BASE+4·WORDS, or addr[1:0] != 0.
  - Error case: `err_o`←1, `rdata_o`←0, and `DATA` is not written.
  - Store: `DATA[index]`←wdata, `err_o`←0, `rdata_o` unchanged.
  - Load: `rdata_o`←`DATA[index]`, `err_o`←0.
- RESP: lasts exactly one cycle and always returns to IDLE. A request is never accepted in RESP.
- Reset (low), asynchronous:
  - state←IDLE, `cnt`←0, `ready_o`=0, `busy_o`=0, `err_o`←0, `rdata_o`←0, and captured registers are cleared.
  - `DATA` is not reset. Under `SIM`, it is zero-initialised at time 0.
  - Reset asserted mid-operation discards the pending request: no store is committed and no response is produced.
- Only word accesses are supported; no byte enables.

## Timing
- Let t0 be the acceptance edge, where IDLE and `req_i`=1.
- The access is performed at edge t0+LATENCY. `ready_o`, `rdata_o`, and `err_o` are valid in the cycle that follows that edge.
- The edge t0+LATENCY+1 returns the FSM to IDLE.
- The earliest next acceptance is edge t0+LATENCY+2. With `req_i` held high continuously, responses therefore repeat every LATENCY+2 cycles.
- A store is visible to a load accepted after its `ready_o` (read-after-write ordering is guaranteed).
- `busy_o` rises in the cycle after t0 and falls in the cycle after RESP.
- Deassertion of `reset` is asynchronous. The first acceptance can occur on the first rising edge with `reset`=1.

## Test plan
- **Store, LATENCY=2:** reset, then store 0x7 to 0x10000060. `ready_o` is high for exactly one cycle after edge t0+2, `err_o`=0, and `DATA[24]`=0x7.
- **Load after store:** load from 0x10000060. `rdata_o`=0x00000007 with `ready_o`, and `rdata_o` holds that value after `ready_o` falls.
- **Error cases:**
  - Store 0xBEEF000 to 0x10000100: `err_o`=1, `rdata_o`=0, and no `DATA` entry changes.
  - Store to 0x10000062: `err_o`=1, `DATA[24]` unchanged.
  - Next valid store to 0x10000070: `err_o` returns to 0.
- **Reset mid-operation:** with `LATENCY`=4, start a store of 0x19 to 0x1000006C and drive `reset` low during WAIT. `ready_o` never pulses, `DATA[27]` keeps its old value, and all outputs read 0 while `reset` is low.
- **Back-to-back requests:** with `LATENCY`=1 and `req_i` held high with fixed fields, `ready_o` pulses every 3 cycles, and `busy_o` is low exactly one cycle between responses.
- **Capture check:** after acceptance of a load from 0x10000000, change `addr_i` to 0x10000004 during WAIT. The response returns `DATA[0]`, not `DATA[1]`.

Source files
------------

// File: rtl/ucsbece154b_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154b_dmem_resp
// Purpose  : Multi-cycle word-addressed data memory that answers load/store
//            requests over a req/ready handshake after a fixed access latency.
//            Storage lives in the word array DATA, mapped at byte address BASE.
// Ports    :
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous, active-low reset
//   req_i    in   1   request valid (held with its fields until ready_o)
//   we_i     in   1   1 = store word, 0 = load word
//   addr_i   in  32   byte address
//   wdata_i  in  32   store data
//   rdata_o  out 32   load data, valid with ready_o and held afterwards
//   ready_o  out  1   one-cycle response strobe
//   err_o    out  1   response is an error, valid with ready_o and held
//   busy_o   out  1   high whenever the FSM is not IDLE
// Revision : 1.0  initial release
// ============================================================================
module ucsbece154b_dmem_resp #(
  parameter int unsigned WORDS   = 64,            // power of two
  parameter logic [31:0] BASE    = 32'h10000000,  // byte address of DATA[0]
  parameter int unsigned LATENCY = 2              // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W    = $clog2(WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [3:0]         cnt_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        DATA [WORDS];

  logic               accept;
  logic               access;
  logic [31:0]        offset;
  logic               addr_err;
  logic [IDX_W-1:0]   idx;

  // Address decode works only on the captured request, so the requester may
  // change its fields freely once the request has been accepted.
  // Range is checked on the offset rather than BASE+SPAN so the upper bound
  // cannot wrap around the 32-bit address space.
  assign offset   = addr_q - BASE;
  assign addr_err = (addr_q < BASE) || (offset >= SPAN) || (addr_q[1:0] != 2'b00);
  assign idx      = offset[IDX_W+1:2];

  assign ready_o  = (state_q == RESP);
  assign busy_o   = (state_q != IDLE);

  // Next-state logic. RESP always falls back to IDLE, so a request held high
  // across a response is only accepted again from IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter, request capture and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_o <= 32'd0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        cnt_q   <= CNT_INIT;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access) begin
        if (addr_err) begin
          err_o   <= 1'b1;
          rdata_o <= 32'd0;
        end else begin
          err_o <= 1'b0;
          // A store leaves rdata_o untouched.
          if (!we_q) begin
            rdata_o <= DATA[idx];
          end
        end
      end
    end
  end

  // Storage is deliberately not reset. A reset during WAIT forces state_q to
  // IDLE, which kills 'access' and therefore discards the pending store.
  always_ff @(posedge clk) begin
    if (access && we_q && !addr_err) begin
      DATA[idx] <= wdata_q;
    end
  end

`ifdef SIM
  initial begin
    for (int i = 0; i < int'(WORDS); i++) begin
      DATA[i] = 32'd0;
    end
  end
`endif

endmodule
`default_nettype wire
